inst_buffer: RTL and testbench



---
 rtl/inst_buffer_pkg.sv | 39 +++
 rtl/inst_buffer.sv | 159 +++++++++++++++
 tb/tb_inst_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared codes for the fetch/issue handshake around the instruction buffer.
// Occupancy codes go to issue; issue-mode codes come back from issue.
package inst_buffer_pkg;

    // Occupancy code presented to issue
    localparam logic [1:0] HaveNoInst  = 2'b00;
    localparam logic [1:0] HaveOneInst = 2'b01;
    localparam logic [1:0] HaveTwoInst = 2'b10;

    // Issue mode returned by issue
    localparam logic [1:0] NoIssue     = 2'b00;
    localparam logic [1:0] SingleIssue = 2'b01;
    localparam logic [1:0] DoubleIssue = 2'b10;

    // Entries consumed by an issue mode; the reserved code retires nothing.
    function automatic logic [1:0] issue_to_count(input logic [1:0] mode);
        logic [1:0] n;
        n = 2'd0;
        case (mode)
            SingleIssue: n = 2'd1;
            DoubleIssue: n = 2'd2;
            default:     n = 2'd0;
        endcase
        return n;
    endfunction

    // Bundles offered by fetch; the reserved value 3 offers nothing.
    function automatic logic [1:0] fetch_to_count(input logic [1:0] cnt);
        logic [1:0] n;
        n = 2'd0;
        case (cnt)
            2'd1:    n = 2'd1;
            2'd2:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and issue.
// Takes up to two bundles per cycle, shows the oldest two to issue and
// retires 0/1/2 per cycle. Flush empties it.
// Optional build macro INSTBUFFER_PERF_EN adds saturating empty/full
// cycle counters (empty_cycles_o, full_cycles_o).
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 131
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [1:0]       fetch_count_i,
    input  logic [WIDTH-1:0] fetch_inst1_bus_i,
    input  logic [WIDTH-1:0] fetch_inst2_bus_i,
    output logic             full_o,
    input  logic [1:0]       issue_mode_i,
    output logic [1:0]       instbuffer_count_o,
    output logic [WIDTH-1:0] inst1_bus_o,
    output logic [WIDTH-1:0] inst2_bus_o
`ifdef INSTBUFFER_PERF_EN
    ,
    output logic [31:0]      empty_cycles_o,
    output logic [31:0]      full_cycles_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW:0] OCC_ZERO   = '0;
    localparam logic [AW:0] OCC_ONE    = (AW+1)'(1);
    localparam logic [AW:0] OCC_TWO    = (AW+1)'(2);
    // Full means fewer than two free slots, so a 2-wide push can never overflow.
    localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH - 2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   occ_q, occ_d;
    logic          full_q, full_d;

    logic [1:0]    offer_n;
    logic [1:0]    issue_n;
    logic [AW:0]   push_cnt;
    logic [AW:0]   pop_cnt;
    logic          wr_first;
    logic          wr_second;
    logic [AW-1:0] tail_p1;

    // Read the entry at head+offset; the pointer sum wraps at DEPTH.
    function automatic logic [WIDTH-1:0] read_at(input logic [AW-1:0] base,
                                                 input logic [AW-1:0] offset);
        logic [AW-1:0] idx;
        idx = base + offset;
        return mem[idx];
    endfunction

    // Decode push/pop amounts; push is dropped entirely while full, pop is clamped.
    always_comb begin
        offer_n  = fetch_to_count(fetch_count_i);
        issue_n  = issue_to_count(issue_mode_i);
        push_cnt = full_q ? OCC_ZERO : (AW+1)'(offer_n);
        pop_cnt  = ((AW+1)'(issue_n) > occ_q) ? occ_q : (AW+1)'(issue_n);
        tail_p1  = tail_q + AW'(1);
        wr_first  = !flush_i && (push_cnt != OCC_ZERO);
        wr_second = !flush_i && (push_cnt == OCC_TWO);
    end

    // Next-state for pointers, occupancy and the registered full flag.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        full_d = full_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            full_d = 1'b0;
        end else begin
            head_d = head_q + pop_cnt[AW-1:0];
            tail_d = tail_q + push_cnt[AW-1:0];
            occ_d  = occ_q + push_cnt - pop_cnt;
            full_d = (occ_d > FULL_LIMIT);
        end
    end

    // Pointer/occupancy state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

    // Storage writes; the array itself is never reset, pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_first) begin
            mem[tail_q] <= fetch_inst1_bus_i;
        end
        if (wr_second) begin
            mem[tail_p1] <= fetch_inst2_bus_i;
        end
    end

    // Issue-side view: occupancy code and the two oldest entries, zeroed when absent.
    always_comb begin
        instbuffer_count_o = HaveNoInst;
        inst1_bus_o        = '0;
        inst2_bus_o        = '0;
        if (occ_q >= OCC_TWO) begin
            instbuffer_count_o = HaveTwoInst;
        end else if (occ_q == OCC_ONE) begin
            instbuffer_count_o = HaveOneInst;
        end
        if (occ_q != OCC_ZERO) begin
            inst1_bus_o = read_at(head_q, AW'(0));
        end
        if (occ_q >= OCC_TWO) begin
            inst2_bus_o = read_at(head_q, AW'(1));
        end
    end

    assign full_o = full_q;

`ifdef INSTBUFFER_PERF_EN
    logic [31:0] empty_cycles_q;
    logic [31:0] full_cycles_q;

    // Saturating occupancy statistics; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            empty_cycles_q <= '0;
            full_cycles_q  <= '0;
        end else begin
            if ((occ_q == OCC_ZERO) && (empty_cycles_q != 32'hFFFF_FFFF)) begin
                empty_cycles_q <= empty_cycles_q + 32'd1;
            end
            if (full_q && (full_cycles_q != 32'hFFFF_FFFF)) begin
                full_cycles_q <= full_cycles_q + 32'd1;
            end
        end
    end

    assign empty_cycles_o = empty_cycles_q;
    assign full_cycles_o  = full_cycles_q;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (default build, DEPTH=16).
module tb_inst_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 131;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic [1:0]       fetch_count_i;
    logic [WIDTH-1:0] fetch_inst1_bus_i;
    logic [WIDTH-1:0] fetch_inst2_bus_i;
    logic             full_o;
    logic [1:0]       issue_mode_i;
    logic [1:0]       instbuffer_count_o;
    logic [WIDTH-1:0] inst1_bus_o;
    logic [WIDTH-1:0] inst2_bus_o;

    int tests;
    int fails;

    inst_buffer #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .fetch_count_i     (fetch_count_i),
        .fetch_inst1_bus_i (fetch_inst1_bus_i),
        .fetch_inst2_bus_i (fetch_inst2_bus_i),
        .full_o            (full_o),
        .issue_mode_i      (issue_mode_i),
        .instbuffer_count_o(instbuffer_count_o),
        .inst1_bus_o       (inst1_bus_o),
        .inst2_bus_o       (inst2_bus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pat(input int unsigned i);
        return {3'b110, 64'hC0DE_0000_0000_0000 ^ 64'(i),
                64'(i) * 64'h0101_0101_0101_0101 + 64'd7};
    endfunction

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i           = 1'b0;
        fetch_count_i     = 2'd0;
        fetch_inst1_bus_i = '0;
        fetch_inst2_bus_i = '0;
        issue_mode_i      = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        tests++;
        if (instbuffer_count_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_count got %0d want 0", instbuffer_count_o);
        end
        tests++;
        if (inst1_bus_o !== '0 || inst2_bus_o !== '0) begin
            fails++;
            $display("FAIL reset_bus got %h / %h want 0", inst1_bus_o, inst2_bus_o);
        end
        tests++;
        if (full_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_full got %b want 0", full_o);
        end
        step();
        tests++;
        if (instbuffer_count_o !== 2'b00 || full_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset got count %0d full %b want 0 0",
                     instbuffer_count_o, full_o);
        end
    endtask

    task automatic test_push_two();
        fetch_count_i     = 2'd2;
        fetch_inst1_bus_i = pat(100);
        fetch_inst2_bus_i = pat(101);
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b10) begin
            fails++;
            $display("FAIL push2_count got %0d want 2", instbuffer_count_o);
        end
        tests++;
        if (inst1_bus_o !== pat(100) || inst2_bus_o !== pat(101)) begin
            fails++;
            $display("FAIL push2_data got %h / %h want %h / %h",
                     inst1_bus_o, inst2_bus_o, pat(100), pat(101));
        end
        issue_mode_i = 2'b10;
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b00 || inst1_bus_o !== '0) begin
            fails++;
            $display("FAIL double_issue got count %0d inst1 %h want 0 0",
                     instbuffer_count_o, inst1_bus_o);
        end
    endtask

    // One push and one single issue per cycle; wraps the pointers twice.
    task automatic test_stream_wrap();
        for (int i = 0; i < 40; i++) begin
            fetch_count_i     = 2'd1;
            fetch_inst1_bus_i = pat(200 + i);
            issue_mode_i      = 2'b01;
            step();
            tests++;
            if (instbuffer_count_o !== 2'b01 || inst1_bus_o !== pat(200 + i) ||
                inst2_bus_o !== '0) begin
                fails++;
                $display("FAIL stream_%0d got count %0d inst1 %h inst2 %h want 1 %h 0",
                         i, instbuffer_count_o, inst1_bus_o, inst2_bus_o, pat(200 + i));
            end
        end
        idle_inputs();
        issue_mode_i = 2'b01;
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b00) begin
            fails++;
            $display("FAIL stream_drain got %0d want 0", instbuffer_count_o);
        end
    endtask

    // Fill to 15 (1 then 2/cycle), check drop while full, then drain in order.
    task automatic test_fill_and_drain();
        int occ;
        int idx;
        occ = 0;
        fetch_count_i     = 2'd1;
        fetch_inst1_bus_i = pat(300);
        step();
        occ = 1;
        for (int k = 0; k < 7; k++) begin
            fetch_count_i     = 2'd2;
            fetch_inst1_bus_i = pat(301 + 2 * k);
            fetch_inst2_bus_i = pat(302 + 2 * k);
            step();
            occ += 2;
            tests++;
            if (full_o !== (occ > 14)) begin
                fails++;
                $display("FAIL fill_full_occ%0d got %b want %b", occ, full_o, occ > 14);
            end
        end
        // Offer while full must be dropped entirely.
        fetch_count_i     = 2'd2;
        fetch_inst1_bus_i = pat(900);
        fetch_inst2_bus_i = pat(901);
        step();
        idle_inputs();
        tests++;
        if (full_o !== 1'b1 || instbuffer_count_o !== 2'b10) begin
            fails++;
            $display("FAIL full_drop got full %b count %0d want 1 2",
                     full_o, instbuffer_count_o);
        end
        tests++;
        if (inst1_bus_o !== pat(300) || inst2_bus_o !== pat(301)) begin
            fails++;
            $display("FAIL full_drop_data got %h / %h want %h / %h",
                     inst1_bus_o, inst2_bus_o, pat(300), pat(301));
        end
        // Drain 15 entries two at a time; the last pop is a clamped double issue.
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (inst1_bus_o !== pat(300 + idx) ||
                inst2_bus_o !== ((occ >= 2) ? pat(301 + idx) : '0)) begin
                fails++;
                $display("FAIL drain_%0d got %h / %h want %h / %h", k, inst1_bus_o,
                         inst2_bus_o, pat(300 + idx), (occ >= 2) ? pat(301 + idx) : '0);
            end
            issue_mode_i = 2'b10;
            step();
            idle_inputs();
            idx += 2;
            occ = (occ >= 2) ? occ - 2 : 0;
        end
        tests++;
        if (instbuffer_count_o !== 2'b00 || full_o !== 1'b0 || inst1_bus_o !== '0) begin
            fails++;
            $display("FAIL drain_end got count %0d full %b inst1 %h want 0 0 0",
                     instbuffer_count_o, full_o, inst1_bus_o);
        end
    endtask

    task automatic test_clamp();
        fetch_count_i     = 2'd1;
        fetch_inst1_bus_i = pat(400);
        step();
        idle_inputs();
        issue_mode_i = 2'b10;
        step();
        tests++;
        if (instbuffer_count_o !== 2'b00) begin
            fails++;
            $display("FAIL clamp_one got %0d want 0", instbuffer_count_o);
        end
        // Over-issue on an empty buffer, then one push must read back alone.
        step();
        idle_inputs();
        fetch_count_i     = 2'd1;
        fetch_inst1_bus_i = pat(401);
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b01 || inst1_bus_o !== pat(401) ||
            inst2_bus_o !== '0 || full_o !== 1'b0) begin
            fails++;
            $display("FAIL clamp_underflow got count %0d inst1 %h full %b want 1 %h 0",
                     instbuffer_count_o, inst1_bus_o, full_o, pat(401));
        end
        // Reserved fetch count and issue mode both act as nothing.
        fetch_count_i     = 2'd3;
        fetch_inst1_bus_i = pat(402);
        fetch_inst2_bus_i = pat(403);
        issue_mode_i      = 2'b11;
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b01 || inst1_bus_o !== pat(401)) begin
            fails++;
            $display("FAIL reserved_codes got count %0d inst1 %h want 1 %h",
                     instbuffer_count_o, inst1_bus_o, pat(401));
        end
        issue_mode_i = 2'b01;
        step();
        idle_inputs();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            fetch_count_i     = 2'd2;
            fetch_inst1_bus_i = pat(500 + 2 * k);
            fetch_inst2_bus_i = pat(501 + 2 * k);
            step();
        end
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b10 || inst1_bus_o !== pat(500)) begin
            fails++;
            $display("FAIL preflush got count %0d inst1 %h want 2 %h",
                     instbuffer_count_o, inst1_bus_o, pat(500));
        end
        flush_i           = 1'b1;
        fetch_count_i     = 2'd2;
        fetch_inst1_bus_i = pat(600);
        fetch_inst2_bus_i = pat(601);
        issue_mode_i      = 2'b10;
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b00 || full_o !== 1'b0 || inst1_bus_o !== '0) begin
            fails++;
            $display("FAIL flush got count %0d full %b inst1 %h want 0 0 0",
                     instbuffer_count_o, full_o, inst1_bus_o);
        end
        fetch_count_i     = 2'd1;
        fetch_inst1_bus_i = pat(700);
        step();
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b01 || inst1_bus_o !== pat(700)) begin
            fails++;
            $display("FAIL post_flush_push got count %0d inst1 %h want 1 %h",
                     instbuffer_count_o, inst1_bus_o, pat(700));
        end
    endtask

    task automatic test_reset_mid();
        rst               = 1'b1;
        fetch_count_i     = 2'd2;
        fetch_inst1_bus_i = pat(800);
        fetch_inst2_bus_i = pat(801);
        step();
        rst = 1'b0;
        idle_inputs();
        tests++;
        if (instbuffer_count_o !== 2'b00 || inst1_bus_o !== '0 || full_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got count %0d inst1 %h full %b want 0 0 0",
                     instbuffer_count_o, inst1_bus_o, full_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_push_two();
        test_stream_wrap();
        test_fill_and_drain();
        test_clamp();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout reached at %0t want finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
